// File: rtl/mem_io_model.sv
// Single-port memory model with an MMIO byte-output FIFO and a pipelined read path.
// Optional watchdog is enabled by defining MEM_IO_WATCHDOG_EN.
module mem_io_model #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned OUT_ADDR   = 'h01,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              timeout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];
  logic [DATA_W-1:0] dat_in_c [RD_LAT];
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;

  logic              is_out_c, cpu_rd_c, push_c, pop_c, full_c, acc_c, ram_we_c;
  logic [PTR_W-1:0]  occ_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [DATA_W-1:0] ram_wdata_c, rd_word_c;

  // Preload has priority and masks every CPU side effect for the cycle.
  always_comb begin
    is_out_c    = (mem_addr == ADDR_W'(OUT_ADDR));
    cpu_rd_c    = !ld_en && !mem_wr;
    push_c      = !ld_en && mem_wr && is_out_c;
    ram_we_c    = ld_en || (mem_wr && !is_out_c);
    ram_waddr_c = ld_en ? ld_addr : mem_addr;
    ram_wdata_c = ld_en ? ld_data : wr_data;
    occ_c       = wr_ptr_q - rd_ptr_q;
    full_c      = (occ_c == PTR_W'(FIFO_DEPTH));
    pop_c       = out_valid_q && out_ready;
    acc_c       = push_c && (!full_c || pop_c);
    rd_word_c   = is_out_c ? DATA_W'(occ_c) : ram_q[mem_addr];
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) ram_q[ram_waddr_c] <= ram_wdata_c;
  end

  // Each stage only loads when a valid enters it, so the last stage holds between reads.
  always_comb begin
    vld_d       = RD_LAT'({vld_q, cpu_rd_c});
    dat_in_c[0] = rd_word_c;
    for (int i = 1; i < RD_LAT; i++) dat_in_c[i] = dat_q[i-1];
    for (int i = 0; i < RD_LAT; i++) dat_d[i] = vld_d[i] ? dat_in_c[i] : dat_q[i];
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (acc_c) begin
      fifo_d[wr_ptr_q[IDX_W-1:0]] = wr_data[7:0];
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else if (push_c) begin
      overflow_d = 1'b1;
    end
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    out_data_d  = fifo_d[rd_ptr_d[IDX_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rd_data   = dat_q[RD_LAT-1];
  assign rd_valid  = vld_q[RD_LAT-1];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

`ifdef MEM_IO_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Saturating cycle counter, restarted by every accepted output byte.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (acc_c) wd_d = '0;
    else if (wd_q < 32'(TIMEOUT)) wd_d = wd_q + 32'd1;
    if (wd_d >= 32'(TIMEOUT)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
